// File: rtl/io_pwr_pkg.sv
// Shared types and default timing constants for the IO bank power sequencer.
package io_pwr_pkg;

  // Sequencer states; encodings are visible on state_o for debug/status.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_PG  = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_BANK_ON  = 3'd3,
    ST_RUN      = 3'd4,
    ST_BANK_OFF = 3'd5,
    ST_FAULT    = 3'd6
  } pwr_state_e;

  localparam int unsigned SETTLE_CYCLES_DEF  = 64;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer for an asynchronous power-good level.
module io_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Resample the async level twice before anyone uses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/io_bank_pwr_seq.sv
// IO ring power sequencer: qualifies VDDIO/VPW power-good, enables pad banks
// one at a time, releases retention, and unwinds in reverse order.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | ring off, retention held
// WAIT_PG   | waiting for qualified power-good, bounded by timeout
// SETTLE    | supplies good, letting them settle before first bank
// BANK_ON   | bank idx just enabled, waiting for it to settle
// RUN       | all banks up, retention released, ready
// BANK_OFF  | retention held, dropping highest enabled bank per step
// FAULT     | timeout or power loss; everything off until cleared
module io_bank_pwr_seq
  import io_pwr_pkg::*;
#(
  parameter int unsigned NUM_BANKS      = 4,
  parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int unsigned CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 pg_vddio_i,
  input  logic                 pg_vpw_i,
  input  logic                 fault_clr_i,
  output logic [NUM_BANKS-1:0] bank_en_o,
  output logic                 pad_ret_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 fault_o,
  output logic [2:0]           state_o
);

  localparam int unsigned IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_BANKS - 1);

  logic pg_vddio_s;
  logic pg_vpw_s;
  logic pg_ok;

  io_sync2 u_sync_vddio (.clk(clk), .rst(rst), .d_i(pg_vddio_i), .q_o(pg_vddio_s));
  io_sync2 u_sync_vpw   (.clk(clk), .rst(rst), .d_i(pg_vpw_i),   .q_o(pg_vpw_s));

  assign pg_ok = pg_vddio_s & pg_vpw_s;

  pwr_state_e           st_q, st_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_BANKS-1:0] bank_q, bank_d;
  logic                 pad_ret_q, ready_q, busy_q, fault_q;

  // Next-state, counter, bank index and bank enable decisions.
  always_comb begin
    st_d   = st_q;
    cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    idx_d  = idx_q;
    bank_d = bank_q;
    unique case (st_q)
      ST_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (start_i && !stop_i) st_d = ST_WAIT_PG;
      end
      ST_WAIT_PG: begin
        if (stop_i) begin
          st_d  = ST_IDLE;
          cnt_d = '0;
        end else if (pg_ok) begin
          st_d  = ST_SETTLE;
          cnt_d = '0;
        end else if (cnt_q == TO_LAST) begin
          st_d  = ST_FAULT;
          cnt_d = '0;
        end
      end
      ST_SETTLE: begin
        if (!pg_ok) begin
          st_d  = ST_FAULT;
          cnt_d = '0;
        end else if (stop_i) begin
          st_d  = ST_BANK_OFF;
          cnt_d = '0;
        end else if (cnt_q == SET_LAST) begin
          st_d      = ST_BANK_ON;
          cnt_d     = '0;
          idx_d     = '0;
          bank_d[0] = 1'b1;
        end
      end
      ST_BANK_ON: begin
        if (!pg_ok) begin
          st_d  = ST_FAULT;
          cnt_d = '0;
        end else if (stop_i) begin
          st_d  = ST_BANK_OFF;
          cnt_d = '0;
        end else if (cnt_q == SET_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            st_d = ST_RUN;
          end else begin
            idx_d         = idx_q + IDX_W'(1);
            bank_d[idx_d] = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!pg_ok) begin
          st_d = ST_FAULT;
        end else if (stop_i) begin
          st_d = ST_BANK_OFF;
        end
      end
      ST_BANK_OFF: begin
        // idx_q always points at the highest bank that may still be on.
        if (bank_q == '0) begin
          st_d  = ST_IDLE;
          cnt_d = '0;
          idx_d = '0;
        end else if (cnt_q == SET_LAST) begin
          bank_d[idx_q] = 1'b0;
          cnt_d         = '0;
          if (idx_q != '0) idx_d = idx_q - IDX_W'(1);
        end
      end
      ST_FAULT: begin
        cnt_d = '0;
        idx_d = '0;
        if (fault_clr_i && !start_i) st_d = ST_IDLE;
      end
      default: begin
        st_d  = ST_IDLE;
        cnt_d = '0;
        idx_d = '0;
      end
    endcase
    // Any entry into FAULT drops every bank on that same edge.
    if (st_d == ST_FAULT) bank_d = '0;
  end

  // State register with outputs decoded from the next state so they are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      bank_q    <= '0;
      pad_ret_q <= 1'b1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      bank_q    <= bank_d;
      pad_ret_q <= (st_d != ST_RUN);
      ready_q   <= (st_d == ST_RUN);
      busy_q    <= (st_d == ST_WAIT_PG) || (st_d == ST_SETTLE) ||
                   (st_d == ST_BANK_ON) || (st_d == ST_BANK_OFF);
      fault_q   <= (st_d == ST_FAULT);
    end
  end

  assign bank_en_o = bank_q;
  assign pad_ret_o = pad_ret_q;
  assign ready_o   = ready_q;
  assign busy_o    = busy_q;
  assign fault_o   = fault_q;
  assign state_o   = st_q;

endmodule

// File: tb/tb_io_bank_pwr_seq.sv
// Directed bench for io_bank_pwr_seq with SETTLE=4, TIMEOUT=16, 4 banks.
module tb_io_bank_pwr_seq;

  logic       clk = 1'b0;
  logic       rst, start_i, stop_i, pg_vddio_i, pg_vpw_i, fault_clr_i;
  logic [3:0] bank_en_o;
  logic       pad_ret_o, ready_o, busy_o, fault_o;
  logic [2:0] state_o;

  int vectors    = 0;
  int miscompares = 0;
  logic watch_ready = 1'b0;
  logic ready_seen  = 1'b0;

  io_bank_pwr_seq #(.NUM_BANKS(4), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
    .pg_vddio_i(pg_vddio_i), .pg_vpw_i(pg_vpw_i), .fault_clr_i(fault_clr_i),
    .bank_en_o(bank_en_o), .pad_ret_o(pad_ret_o), .ready_o(ready_o),
    .busy_o(busy_o), .fault_o(fault_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (watch_ready && ready_o) ready_seen <= 1'b1;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks bank_en, pad_ret, ready, busy, fault, state together.
  task automatic check_all(input string tag, input logic [3:0] bank, input logic ret,
                           input logic rdy, input logic bsy, input logic flt,
                           input logic [2:0] st);
    check({tag, ".bank"},  {4'h0, bank_en_o}, {4'h0, bank});
    check({tag, ".ret"},   {7'h0, pad_ret_o}, {7'h0, ret});
    check({tag, ".ready"}, {7'h0, ready_o},   {7'h0, rdy});
    check({tag, ".busy"},  {7'h0, busy_o},    {7'h0, bsy});
    check({tag, ".fault"}, {7'h0, fault_o},   {7'h0, flt});
    check({tag, ".state"}, {5'h0, state_o},   {5'h0, st});
  endtask

  initial begin
    rst = 1'b1; start_i = 0; stop_i = 0; pg_vddio_i = 0; pg_vpw_i = 0; fault_clr_i = 0;
    tick(2);
    check_all("reset", 4'b0000, 1, 0, 0, 0, 3'd0);
    rst = 1'b0;
    pg_vddio_i = 1; pg_vpw_i = 1;
    tick(2);

    // stop has priority over start in IDLE
    start_i = 1; stop_i = 1;
    tick(1);
    check_all("idle_stop_prio", 4'b0000, 1, 0, 0, 0, 3'd0);
    stop_i = 0;

    // Normal power-up
    tick(1);
    check_all("up_wait", 4'b0000, 1, 0, 1, 0, 3'd1);
    tick(1);
    check_all("up_settle", 4'b0000, 1, 0, 1, 0, 3'd2);
    tick(3);
    check_all("up_settle_end", 4'b0000, 1, 0, 1, 0, 3'd2);
    tick(1);
    check_all("up_b0", 4'b0001, 1, 0, 1, 0, 3'd3);
    tick(4);
    check_all("up_b1", 4'b0011, 1, 0, 1, 0, 3'd3);
    tick(4);
    check_all("up_b2", 4'b0111, 1, 0, 1, 0, 3'd3);
    tick(3);
    check_all("up_b2_hold", 4'b0111, 1, 0, 1, 0, 3'd3);
    tick(1);
    check_all("up_b3", 4'b1111, 1, 0, 1, 0, 3'd3);
    tick(3);
    check_all("up_b3_hold", 4'b1111, 1, 0, 1, 0, 3'd3);
    tick(1);
    check_all("up_run", 4'b1111, 0, 1, 0, 0, 3'd4);

    // Ordered shutdown
    start_i = 0; stop_i = 1;
    tick(1);
    check_all("dn_enter", 4'b1111, 1, 0, 1, 0, 3'd5);
    tick(4);
    check_all("dn_0111", 4'b0111, 1, 0, 1, 0, 3'd5);
    tick(4);
    check_all("dn_0011", 4'b0011, 1, 0, 1, 0, 3'd5);
    tick(4);
    check_all("dn_0001", 4'b0001, 1, 0, 1, 0, 3'd5);
    tick(4);
    check_all("dn_0000", 4'b0000, 1, 0, 1, 0, 3'd5);
    tick(1);
    check_all("dn_idle", 4'b0000, 1, 0, 0, 0, 3'd0);
    stop_i = 0;

    // Abort during power-up at 0011
    watch_ready = 1'b1;
    start_i = 1;
    tick(2);
    check_all("ab_settle", 4'b0000, 1, 0, 1, 0, 3'd2);
    tick(8);
    check_all("ab_0011", 4'b0011, 1, 0, 1, 0, 3'd3);
    start_i = 0; stop_i = 1;
    tick(1);
    check_all("ab_enter", 4'b0011, 1, 0, 1, 0, 3'd5);
    tick(4);
    check_all("ab_0001", 4'b0001, 1, 0, 1, 0, 3'd5);
    tick(4);
    check_all("ab_0000", 4'b0000, 1, 0, 1, 0, 3'd5);
    tick(1);
    check_all("ab_idle", 4'b0000, 1, 0, 0, 0, 3'd0);
    watch_ready = 1'b0;
    check("ab_ready_never", {7'h0, ready_seen}, 8'h00);
    stop_i = 0;

    // Power drop in RUN
    start_i = 1;
    tick(22);
    check_all("pd_run", 4'b1111, 0, 1, 0, 0, 3'd4);
    pg_vddio_i = 0;
    tick(2);
    check_all("pd_lat2", 4'b1111, 0, 1, 0, 0, 3'd4);
    tick(1);
    check_all("pd_fault", 4'b0000, 1, 0, 0, 1, 3'd6);

    // Fault clear held while start is high, taken once start is low
    fault_clr_i = 1;
    tick(1);
    fault_clr_i = 0;
    check_all("fc_held", 4'b0000, 1, 0, 0, 1, 3'd6);
    start_i = 0; fault_clr_i = 1;
    tick(1);
    fault_clr_i = 0;
    check_all("fc_clear", 4'b0000, 1, 0, 0, 0, 3'd0);

    // Timeout waiting for power-good
    pg_vddio_i = 1; pg_vpw_i = 0;
    tick(3);
    start_i = 1;
    tick(1);
    check_all("to_wait", 4'b0000, 1, 0, 1, 0, 3'd1);
    tick(15);
    check_all("to_edge", 4'b0000, 1, 0, 1, 0, 3'd1);
    tick(1);
    check_all("to_fault", 4'b0000, 1, 0, 0, 1, 3'd6);
    start_i = 0; fault_clr_i = 1;
    tick(1);
    fault_clr_i = 0;
    check_all("to_clear", 4'b0000, 1, 0, 0, 0, 3'd0);

    // Reset mid-sequence drops banks immediately
    pg_vpw_i = 1;
    tick(2);
    start_i = 1;
    tick(10);
    check_all("rs_pre", 4'b0011, 1, 0, 1, 0, 3'd3);
    rst = 1;
    tick(1);
    check_all("rs_mid", 4'b0000, 1, 0, 0, 0, 3'd0);
    rst = 0; start_i = 0;
    tick(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
